// File: rtl/jk_bank.sv
// WIDTH-channel JK register bank with per-cycle JK / T / D / up-down count modes,
// clock enable, complementary outputs, a registered change flag and a terminal-count flag.
module jk_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             chg,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'd0,
        MODE_T     = 2'd1,
        MODE_D     = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    mode_t            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic             cnt_up;
    logic             cnt_dn;
    logic             cnt_clr;

    assign mode_sel = mode_t'(mode);

    // Counting is steered only by channel 0's control pair.
    assign cnt_up  =  j[0] & ~k[0];
    assign cnt_dn  = ~j[0] &  k[0];
    assign cnt_clr =  j[0] &  k[0];

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_next = q;
        unique case (mode_sel)
            MODE_JK: begin
                for (int i = 0; i < WIDTH; i++) begin
                    unique case ({j[i], k[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   q_next[i] = ~q[i];
                        default: q_next[i] = q[i];
                    endcase
                end
            end
            MODE_T:  q_next = q ^ j;
            MODE_D:  q_next = j;
            MODE_COUNT: begin
                if (cnt_up)
                    q_next = q + WIDTH'(1);
                else if (cnt_dn)
                    q_next = q - WIDTH'(1);
                else if (cnt_clr)
                    q_next = '0;   // clears to zero, deliberately not RESET_VAL
                else
                    q_next = q;
            end
            default: q_next = q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= RESET_VAL;
            chg <= 1'b0;
        end else if (en) begin
            q   <= q_next;
            chg <= (q_next != q);
        end else begin
            chg <= 1'b0;
        end
    end

    assign qn = ~q;

    // Flags the edge that would carry or borrow out; independent of en.
    assign tc = (mode_sel == MODE_COUNT) &
                ((cnt_up & (&q)) | (cnt_dn & ~(|q)));

endmodule

// File: doc/jk_bank.md
# jk_bank

Parametrised register bank of WIDTH JK flip-flop channels. Extends the single-bit JK flip-flop with a channel width, a clock enable, asynchronous active-low reset, selectable per-cycle mode (JK, T, D, up/down counter), complementary outputs and a registered change flag. It is the general-purpose storage/toggle/count primitive for the learning designs and is driven directly by testbench stimulus or small control FSMs.

## Interface
- WIDTH, 4, number of channels (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- en  input  1  clock enable; 0 = hold all state
- mode  input  2  operating mode: 0 JK, 1 T, 2 D, 3 COUNT
- j  input  WIDTH  per-channel J / T / D data / count control (bit 0 only in COUNT)
- k  input  WIDTH  per-channel K / count control (bit 0 only in COUNT)
- q  output  WIDTH  registered state
- qn  output  WIDTH  ~q, always (combinational inverse of q register)
- chg  output  1  registered; 1 for one cycle after an edge that changed q
- tc  output  1  combinational terminal-count flag (COUNT mode only)

## Operation
- Reset (rst_n=0, asynchronous, no clock needed): q=RESET_VAL, qn=~RESET_VAL, chg=0. Reset asserted mid-operation overrides everything immediately; first update after release is on the first rising clk with rst_n=1.
- en=0 at an edge: q holds, chg<=0. mode/j/k ignored.
- en=1, mode 0 (JK), per bit i: j,k = 00 hold; 10 set to 1; 01 clear to 0; 11 toggle.
- en=1, mode 1 (T): q[i] toggles where j[i]=1, else holds; k ignored.
- en=1, mode 2 (D): q <= j; k ignored.
- en=1, mode 3 (COUNT), controlled by {j[0],k[0]} only; other bits ignored:
  - 10: q <= q+1 modulo 2^WIDTH (all-ones wraps to 0)
  - 01: q <= q-1 modulo 2^WIDTH (0 wraps to all-ones)
  - 00: hold
  - 11: synchronous clear, q <= 0 (not RESET_VAL)
- chg <= (next q != current q) on every enabled edge; 0 on disabled edges.
- tc = (mode==3) & ((j[0]&~k[0]&q==all-ones) | (~j[0]&k[0]&q==0)); 0 in all other modes, independent of en.
- Mode may change every cycle; no internal state beyond q and chg, so no transition penalty.
- Arithmetic is unsigned WIDTH-bit; carry/borrow discarded (reflected only in tc).

## Timing
- Latency: inputs sampled at rising edge N; q valid after edge N; chg for edge N valid after edge N (same cycle as new q).
- qn, tc are combinational from registered q plus inputs; no added latency.
- No handshake; every enabled edge performs exactly one operation.
- rst_n deassertion must meet recovery/removal to clk; bench releases rst_n on clk falling edge.

## Test plan
- Async reset: run COUNT up from 0101, drop rst_n between edges -> q=0000, qn=1111, chg=0 immediately, before next edge; hold stays through edges while rst_n=0.
- JK mode, WIDTH=4, q=0000, j=0011 k=0101 for one edge -> q=0011, chg=1; repeat same inputs -> q=0010 (bit0 toggles), chg=1; then j=k=0000 -> q=0010, chg=0.
- T and D: q=0010, mode 1 j=1111 -> q=1101; mode 2 j=1010 -> q=1010, chg=1; mode 2 j=1010 again -> chg=0.
- COUNT wrap: load 1110 via D, mode 3 j[0]=1 k[0]=0 -> q=1111 with tc=1, next edge q=0000 tc=0; switch to down (j0=0,k0=1) at 0000 -> tc=1, next edge q=1111; j0=k0=1 -> q=0000.
- Enable: q=0110, en=0 with mode 1 j=1111 for 3 edges -> q stays 0110, chg=0; en=1 next edge -> q=1001, chg=1.
- Parameter sweep: WIDTH=1, RESET_VAL=1 -> reset q=1; COUNT up -> 0 with tc=1 before edge; WIDTH=8 COUNT up from 11111111 -> 00000000.
